// File: rtl/subr_stack_ctrl.sv
// -----------------------------------------------------------------------------
// subr_stack_ctrl
//
// Subroutine call/return sequencer for the bit-serial return stack of the
// MicroEV20 core. A call serializes a parallel return address into the stack
// as a train of push strobes, LSB first. A return issues pop strobes, collects
// the LIFO bits (MSB first) and reassembles the address. The block also tracks
// frame depth and flags overflow/underflow.
//
// Ports
//   clk        in   system clock, rising edge
//   rstn       in   asynchronous active-low reset (shared with the stack)
//   call_req   in   push call_addr as a new frame (sampled only when idle)
//   call_addr  in   [AW] return address to save
//   ret_req    in   pop one frame (sampled only when idle, wins over call_req)
//   busy       out  push or pop sequence in progress
//   ret_addr   out  [AW] last reassembled return address
//   ret_valid  out  one-cycle pulse when ret_addr is updated
//   err_ovf    out  one-cycle pulse: call rejected, stack full
//   err_unf    out  one-cycle pulse: return rejected, stack empty
//   depth      out  [$clog2(DEPTH+1)] current frame count
//   stk_in     out  serial data bit to the stack
//   stk_push   out  push strobe, stack samples on its rising edge
//   stk_pop    out  pop strobe, stack updates stk_lifo on its rising edge
//   stk_lifo   in   LIFO output bit from the stack
//
// Every output is a register; next values are derived from the next state so
// the strobes line up with the state they belong to without any output decode
// glitches reaching the stack.
// -----------------------------------------------------------------------------
module subr_stack_ctrl #(
    parameter  int AW    = 4,
    parameter  int DEPTH = 2,
    localparam int DW    = $clog2(DEPTH + 1),
    localparam int CW    = $clog2(AW + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          call_req,
    input  logic [AW-1:0] call_addr,
    input  logic          ret_req,
    output logic          busy,
    output logic [AW-1:0] ret_addr,
    output logic          ret_valid,
    output logic          err_ovf,
    output logic          err_unf,
    output logic [DW-1:0] depth,
    output logic          stk_in,
    output logic          stk_push,
    output logic          stk_pop,
    input  logic          stk_lifo
);

    typedef enum logic [2:0] {
        IDLE,
        PUSH_HI,
        PUSH_LO,
        POP_HI,
        POP_CAP,
        DONE
    } state_t;

    localparam logic [CW-1:0] CNT_LAST  = CW'(AW - 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    state_t        state, state_nx;
    logic [AW-1:0] shift, shift_nx;     // push data on calls, rebuild on returns
    logic [CW-1:0] cnt, cnt_nx;         // bits moved in the current frame
    logic [DW-1:0] depth_nx;
    logic [AW-1:0] ret_addr_nx;
    logic          stk_in_nx;
    logic          ovf_nx, unf_nx;

    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nx    = state;
        shift_nx    = shift;
        cnt_nx      = cnt;
        depth_nx    = depth;
        ret_addr_nx = ret_addr;
        ovf_nx      = 1'b0;
        unf_nx      = 1'b0;

        case (state)
            IDLE: begin
                // Return has priority; a simultaneous call is dropped silently.
                if (ret_req) begin
                    if (depth == '0) begin
                        unf_nx = 1'b1;
                    end else begin
                        cnt_nx   = '0;
                        state_nx = POP_HI;
                    end
                end else if (call_req) begin
                    if (depth == DEPTH_MAX) begin
                        ovf_nx = 1'b1;
                    end else begin
                        shift_nx = call_addr;
                        cnt_nx   = '0;
                        state_nx = PUSH_HI;
                    end
                end
            end

            PUSH_HI: state_nx = PUSH_LO;

            PUSH_LO: begin
                shift_nx = shift >> 1;
                if (cnt == CNT_LAST) begin
                    cnt_nx   = '0;
                    depth_nx = depth + DW'(1);
                    state_nx = IDLE;
                end else begin
                    cnt_nx   = cnt + CW'(1);
                    state_nx = PUSH_HI;
                end
            end

            POP_HI: state_nx = POP_CAP;

            POP_CAP: begin
                // The stack returns the MSB first, so shifting left rebuilds
                // the address in its original bit order.
                shift_nx = {shift[AW-2:0], stk_lifo};
                if (cnt == CNT_LAST) begin
                    cnt_nx      = '0;
                    ret_addr_nx = shift_nx;
                    state_nx    = DONE;
                end else begin
                    cnt_nx   = cnt + CW'(1);
                    state_nx = POP_HI;
                end
            end

            DONE: begin
                depth_nx = depth - DW'(1);
                state_nx = IDLE;
            end

            default: state_nx = IDLE;
        endcase

        // stk_in moves only when a new push pulse starts and is held otherwise,
        // so the stack sees stable data across the whole strobe.
        stk_in_nx = (state_nx == PUSH_HI) ? shift_nx[0] : stk_in;
    end

    // NOTE: the strobes are reset asynchronously, so asserting rstn mid-frame
    // drops them at once instead of waiting for the next clock edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            shift     <= '0;
            cnt       <= '0;
            depth     <= '0;
            ret_addr  <= '0;
            ret_valid <= 1'b0;
            err_ovf   <= 1'b0;
            err_unf   <= 1'b0;
            busy      <= 1'b0;
            stk_in    <= 1'b0;
            stk_push  <= 1'b0;
            stk_pop   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state     <= state_nx;
            shift     <= shift_nx;
            cnt       <= cnt_nx;
            depth     <= depth_nx;
            ret_addr  <= ret_addr_nx;
            ret_valid <= (state_nx == DONE);
            err_ovf   <= ovf_nx;
            err_unf   <= unf_nx;
            busy      <= (state_nx != IDLE);
            stk_in    <= stk_in_nx;
            stk_push  <= (state_nx == PUSH_HI);
            stk_pop   <= (state_nx == POP_HI);
        end
    end

endmodule

// File: tb/tb_subr_stack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_subr_stack_ctrl
//
// Self-checking bench for subr_stack_ctrl. A bit-level serial stack model
// answers the push/pop strobes; a frame-level queue predicts depth and the
// returned addresses. Per-cycle expectations are derived from the cycle-count
// rules of a call/return sequence.
// -----------------------------------------------------------------------------
module tb_subr_stack_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 2;
    localparam int DW    = $clog2(DEPTH + 1);

    typedef enum {K_IDLE, K_PUSH, K_POP, K_OVF, K_UNF} kind_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          call_req = 1'b0;
    logic [AW-1:0] call_addr = '0;
    logic          ret_req = 1'b0;
    logic          busy;
    logic [AW-1:0] ret_addr;
    logic          ret_valid;
    logic          err_ovf;
    logic          err_unf;
    logic [DW-1:0] depth;
    logic          stk_in;
    logic          stk_push;
    logic          stk_pop;
    logic          stk_lifo = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] frames[$];   // frame-level reference: one entry per call

    subr_stack_ctrl #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .call_req  (call_req),
        .call_addr (call_addr),
        .ret_req   (ret_req),
        .busy      (busy),
        .ret_addr  (ret_addr),
        .ret_valid (ret_valid),
        .err_ovf   (err_ovf),
        .err_unf   (err_unf),
        .depth     (depth),
        .stk_in    (stk_in),
        .stk_push  (stk_push),
        .stk_pop   (stk_pop),
        .stk_lifo  (stk_lifo)
    );

    always #5 clk = ~clk;

    // Serial stack model. Data is taken as the push strobe falls; stk_in is
    // held for the whole pulse, so this equals sampling on the rising edge.
    bit stack_bits[$];
    bit push_q = 1'b0;
    bit pop_q  = 1'b0;
    always @(stk_push or stk_pop or negedge rstn) begin
        if (!rstn) begin
            stack_bits.delete();
            stk_lifo = 1'b0;
        end else begin
            if (stk_pop && !pop_q)
                stk_lifo = (stack_bits.size() > 0) ? stack_bits.pop_back() : 1'b0;
            if (!stk_push && push_q)
                stack_bits.push_back(stk_in);
        end
        push_q = stk_push;
        pop_q  = stk_pop;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One request issued in IDLE, followed cycle by cycle. Cycle k is the
    // k-th cycle after the accepting edge, sampled at the falling edge.
    // glitch > 0 raises both requests during that cycle to show they are ignored.
    task automatic run_op(input bit c, input bit r, input logic [AW-1:0] a, input int glitch);
        kind_t         kind;
        int            d0, ncyc;
        logic [AW-1:0] exp_ret;
        logic [5:0]    exp_v, obs_v;
        bit            odd_pulse;

        d0      = frames.size();
        exp_ret = '0;
        if (r)      kind = (d0 == 0)     ? K_UNF : K_POP;
        else if (c) kind = (d0 == DEPTH) ? K_OVF : K_PUSH;
        else        kind = K_IDLE;
        if (kind == K_POP) exp_ret = frames[$];

        case (kind)
            K_PUSH:  ncyc = 2 * AW + 1;
            K_POP:   ncyc = 2 * AW + 2;
            default: ncyc = 2;
        endcase

        @(negedge clk);
        call_req  = c;
        ret_req   = r;
        call_addr = a;

        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (k == 1) begin
                call_req = 1'b0;
                ret_req  = 1'b0;
            end
            odd_pulse = (k % 2 == 1) && (k < 2 * AW);
            exp_v = {(kind == K_PUSH && k <= 2 * AW) || (kind == K_POP && k <= 2 * AW + 1),
                     kind == K_PUSH && odd_pulse,
                     kind == K_POP && odd_pulse,
                     kind == K_POP && k == 2 * AW + 1,
                     kind == K_OVF && k == 1,
                     kind == K_UNF && k == 1};
            obs_v = {busy, stk_push, stk_pop, ret_valid, err_ovf, err_unf};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL ctrl kind=%s cycle=%0d {busy,push,pop,valid,ovf,unf} got=%b want=%b",
                         kind.name(), k, obs_v, exp_v);
            end
            if (kind == K_PUSH && odd_pulse) begin
                n_checks++;
                if (stk_in !== a[(k - 1) / 2]) begin
                    n_fail++;
                    $display("FAIL stk_in cycle=%0d got=%b want=%b", k, stk_in, a[(k - 1) / 2]);
                end
            end
            if (kind == K_POP && k == 2 * AW + 1) begin
                n_checks++;
                if (ret_addr !== exp_ret) begin
                    n_fail++;
                    $display("FAIL ret_addr got=%h want=%h", ret_addr, exp_ret);
                end
            end
            if (k == glitch) begin
                call_req  = 1'b1;
                ret_req   = 1'b1;
                call_addr = ~a;
            end else if (k == glitch + 1) begin
                call_req = 1'b0;
                ret_req  = 1'b0;
            end
        end

        if (kind == K_PUSH) frames.push_back(a);
        if (kind == K_POP)  void'(frames.pop_back());

        n_checks++;
        if (depth !== DW'(frames.size())) begin
            n_fail++;
            $display("FAIL depth after %s got=%0d want=%0d", kind.name(), depth, frames.size());
        end
    endtask

    task automatic test_reset();
        logic [AW+DW+6:0] obs;
        #1 rstn = 1'b0;
        #11;
        obs = {busy, stk_push, stk_pop, ret_valid, err_ovf, err_unf, stk_in, ret_addr, depth};
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b want=all zero", obs);
        end
        @(negedge clk);
        rstn = 1'b1;
        frames.delete();
        @(negedge clk);
        n_checks++;
        if ({busy, depth} !== '0) begin
            n_fail++;
            $display("FAIL post_reset busy=%b depth=%0d want busy=0 depth=0", busy, depth);
        end
    endtask

    task automatic test_single_call();
        run_op(1'b1, 1'b0, 4'hA, 0);
    endtask

    task automatic test_nesting();
        run_op(1'b1, 1'b0, 4'h3, 0);
        run_op(1'b0, 1'b1, 4'h0, 0);   // returns 4'h3
        run_op(1'b0, 1'b1, 4'h0, 0);   // returns 4'hA
    endtask

    task automatic test_errors();
        run_op(1'b0, 1'b1, 4'h0, 0);   // underflow at depth 0
        run_op(1'b1, 1'b0, 4'h5, 0);
        run_op(1'b1, 1'b0, 4'hC, 0);
        run_op(1'b1, 1'b0, 4'h7, 0);   // overflow at depth 2
        run_op(1'b0, 1'b1, 4'h0, 0);
        run_op(1'b0, 1'b1, 4'h0, 0);
    endtask

    task automatic test_collision();
        run_op(1'b1, 1'b0, 4'h2, 0);
        run_op(1'b1, 1'b1, 4'hF, 0);   // return wins, call dropped
        run_op(1'b1, 1'b0, 4'h8, 3);   // requests pulsed mid-push
        run_op(1'b0, 1'b1, 4'h0, 3);   // requests pulsed mid-pop
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            run_op(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                   AW'($urandom_range(0, (1 << AW) - 1)), 0);
    endtask

    task automatic test_async_reset();
        logic [2:0] obs;
        while (frames.size() > 0) run_op(1'b0, 1'b1, 4'h0, 0);
        run_op(1'b1, 1'b0, 4'hB, 0);
        @(negedge clk);
        call_req  = 1'b1;
        call_addr = 4'h6;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            call_req = 1'b0;
        end
        n_checks++;
        if (stk_push !== 1'b1) begin
            n_fail++;
            $display("FAIL third_push_pulse stk_push got=%b want=1", stk_push);
        end
        #1 rstn = 1'b0;
        #1;
        obs = {stk_push, busy, depth == '0};
        n_checks++;
        if (obs !== 3'b001) begin
            n_fail++;
            $display("FAIL async_reset {push,busy,depth==0} got=%b want=001", obs);
        end
        frames.delete();
        @(negedge clk);
        rstn = 1'b1;
        run_op(1'b1, 1'b0, 4'h9, 0);
        run_op(1'b0, 1'b1, 4'h0, 0);
    endtask

    initial begin
        test_reset();
        test_single_call();
        test_nesting();
        test_errors();
        test_collision();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/subr_stack_ctrl.md
# subr_stack_ctrl

Subroutine call/return sequencer that drives the bit-serial return stack of the MicroEV20 core. On a call it serializes a parallel return address into the stack as a train of push strobes. On a return it issues pop strobes, collects the LIFO bits and reassembles the address. It also tracks frame depth and flags overflow and underflow; it sits between the instruction decoder and the serial stack.

## Interface
- AW, 4, return-address width in bits (bits per frame)
- DEPTH, 2, maximum number of frames; the attached stack holds at least DEPTH*AW bits
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- call_req  in  1  request to push call_addr; sampled only in IDLE
- call_addr  in  AW  return address to save; captured when call_req is accepted
- ret_req  in  1  request to pop one frame; sampled only in IDLE
- busy  out  1  high while a push or pop sequence is in progress
- ret_addr  out  AW  last reassembled return address; holds until the next return completes
- ret_valid  out  1  one-cycle pulse when ret_addr is updated
- err_ovf  out  1  one-cycle pulse when a call is rejected at depth==DEPTH
- err_unf  out  1  one-cycle pulse when a return is rejected at depth==0
- depth  out  $clog2(DEPTH+1)  current frame count
- stk_in  out  1  serial data bit to the stack
- stk_push  out  1  push strobe; the stack samples on its rising edge
- stk_pop  out  1  pop strobe; the stack updates its LIFO output on its rising edge
- stk_lifo  in  1  LIFO output bit from the stack

## Operation
- All outputs are registered. Reset values: every output 0, state IDLE, bit counter 0, shift register 0.
- FSM states: IDLE, PUSH_HI, PUSH_LO, POP_HI, POP_CAP, DONE.
- IDLE, ret_req=1:
  - depth==0: pulse err_unf, stay in IDLE.
  - otherwise: go to POP_HI.
- IDLE, call_req=1 and ret_req=0:
  - depth==DEPTH: pulse err_ovf, stay in IDLE.
  - otherwise: load call_addr into the shift register and go to PUSH_HI.
- ret_req has priority. With both requests high, the call is dropped silently and no error is raised.
- Push order is LSB first: addr[0], addr[1], … addr[AW-1].
- PUSH_HI: stk_push=1 and stk_in=current bit, then go to PUSH_LO.
- PUSH_LO: stk_push=0 and stk_in is held. Shift to the next bit. After AW bits, depth+1 and go to IDLE; otherwise go to PUSH_HI.
- stk_in changes only on entry to PUSH_HI and holds its last value otherwise.
- Pops return the MSB first. POP_HI: stk_pop=1, then go to POP_CAP.
- POP_CAP: stk_pop=0. At the end of the cycle, capture stk_lifo as rebuild={rebuild[AW-2:0],stk_lifo}. After AW captures go to DONE; otherwise go to POP_HI.
- DONE: ret_addr=rebuild, ret_valid=1, depth-1, then go to IDLE.
- Requests arriving while busy are ignored; nothing is queued.
- Reset mid-operation:
  - Strobes drop to 0 immediately and the FSM returns to IDLE.
  - depth is cleared. Any partial frame is abandoned; the stack shares rstn.

## Timing
- Call accepted at edge t0:
  - Push strobes are high in cycles 1, 3, … 2*AW-1.
  - busy is high in cycles 1 through 2*AW.
  - depth is incremented and visible in cycle 2*AW+1, when the next request can be accepted.
- Return accepted at t0:
  - Pop strobes are high in cycles 1, 3, … 2*AW-1.
  - stk_lifo is captured in cycles 2, 4, … 2*AW.
  - DONE, the ret_valid pulse and the ret_addr update occur in cycle 2*AW+1; busy stays high through DONE.
  - depth is updated and a new request can be accepted in cycle 2*AW+2.
- err_ovf and err_unf pulse in cycle 1 after the rejected request; busy stays low.
- Every strobe is one cycle high followed by at least one cycle low, giving clean rising edges.

## Test plan
- Reset: assert rstn=0 -> all outputs 0, depth=0; release -> IDLE, busy=0.
- Single call (AW=4): call_addr=4'hA -> stk_in=0,1,0,1 on push pulses in cycles 1,3,5,7; busy in cycles 1–8; depth=1 in cycle 9.
- Nesting, with a behavioural serial-stack model:
  - Stimulus: call 4'hA, call 4'h3, ret, ret.
  - Response: ret_addr=4'h3, then 4'hA, each with ret_valid in cycle 9 of its return; depth goes 1,2,1,0.
- Errors:
  - ret at depth 0 -> err_unf one-cycle pulse, no stk_pop.
  - Third call at depth 2 -> err_ovf pulse, no stk_push, depth stays 2.
- Collisions:
  - call_req=ret_req=1 at depth 1 -> pop sequence runs and the call is dropped.
  - call_req pulsed mid-sequence -> ignored.
- Async reset during the third push pulse -> stk_push=0 without waiting for clk, busy=0, depth=0; a new call is accepted after release.
